// File: rtl/eth_link_reset_seq.sv
// Ethernet MAC link reset sequencer.
// Walks the MAC through csr -> tx -> rx reset release. Each stage waits on
// synchronized status, with a per-stage timeout and a bounded retry budget.
module eth_link_reset_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       i_reconfig_clk,
    input  logic       i_reconfig_reset,
    input  logic       i_restart,
    input  logic       i_tx_pll_locked,
    input  logic       i_cdr_lock,
    input  logic       i_ehip_ready,
    input  logic       i_tx_lanes_stable,
    input  logic       i_rx_pcs_ready,
    output logic       o_csr_rst_n,
    output logic       o_tx_rst_n,
    output logic       o_rx_rst_n,
    output logic       o_link_up,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [3:0] o_retry_cnt
);

    localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_TOP    = {TW{1'b1}};
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    // Bit positions of the status bundle
    localparam int PLL   = 4;
    localparam int CDR   = 3;
    localparam int EHIP  = 2;
    localparam int LANES = 1;
    localparam int PCS   = 0;

    typedef enum logic [2:0] {
        RESET_ALL = 3'd0,
        WAIT_EHIP = 3'd1,
        WAIT_TX   = 3'd2,
        WAIT_RX   = 3'd3,
        LINK_UP   = 3'd4,
        RX_RETRY  = 3'd5,
        FAIL      = 3'd6
    } state_t;

    logic [4:0] status_raw;
    logic [4:0] sync1_reg;
    logic [4:0] sync2_reg;

    state_t         state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [3:0]     retry_reg, retry_next;
    logic           exit_ok;
    logic           in_wait;

    logic csr_rst_n_reg, csr_rst_n_next;
    logic tx_rst_n_reg,  tx_rst_n_next;
    logic rx_rst_n_reg,  rx_rst_n_next;
    logic link_up_reg,   link_up_next;
    logic fail_reg,      fail_next;

    assign status_raw = {i_tx_pll_locked, i_cdr_lock, i_ehip_ready,
                         i_tx_lanes_stable, i_rx_pcs_ready};

    // Two-flop synchronizer per asynchronous status input
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_sync
            always_ff @(posedge i_reconfig_clk) begin
                if (i_reconfig_reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= status_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // State, timer, retry counter and registered outputs
    always_ff @(posedge i_reconfig_clk) begin
        if (i_reconfig_reset) begin
            state_reg     <= RESET_ALL;
            timer_reg     <= '0;
            retry_reg     <= '0;
            csr_rst_n_reg <= 1'b0;
            tx_rst_n_reg  <= 1'b0;
            rx_rst_n_reg  <= 1'b0;
            link_up_reg   <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            csr_rst_n_reg <= csr_rst_n_next;
            tx_rst_n_reg  <= tx_rst_n_next;
            rx_rst_n_reg  <= rx_rst_n_next;
            link_up_reg   <= link_up_next;
            fail_reg      <= fail_next;
        end
    end

    // Next-state, timer and retry logic; restart beats everything else
    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        exit_ok    = 1'b0;
        in_wait    = 1'b0;

        case (state_reg)
            RESET_ALL: if (timer_reg == HOLD_LAST) state_next = WAIT_EHIP;
            WAIT_EHIP: begin
                in_wait = 1'b1;
                exit_ok = sync2_reg[EHIP] & sync2_reg[PLL];
                if (exit_ok) state_next = WAIT_TX;
            end
            WAIT_TX: begin
                in_wait = 1'b1;
                exit_ok = sync2_reg[LANES] & sync2_reg[CDR];
                if (exit_ok) state_next = WAIT_RX;
            end
            WAIT_RX: begin
                in_wait = 1'b1;
                exit_ok = sync2_reg[PCS];
                if (exit_ok) state_next = LINK_UP;
            end
            LINK_UP: begin
                if (!sync2_reg[PLL])      state_next = RESET_ALL;
                else if (!sync2_reg[PCS]) state_next = RX_RETRY;
            end
            RX_RETRY:  if (timer_reg == HOLD_LAST) state_next = WAIT_TX;
            FAIL:      state_next = FAIL;
            default:   state_next = RESET_ALL;
        endcase

        // Timeout only when the exit condition did not fire this cycle
        if (in_wait && !exit_ok && (timer_reg == TIMEOUT_LAST)) begin
            retry_next = (retry_reg >= RETRY_LIMIT) ? RETRY_LIMIT : retry_reg + 4'd1;
            if (retry_next == RETRY_LIMIT)  state_next = FAIL;
            else if (state_reg == WAIT_RX)  state_next = RX_RETRY;
            else                            state_next = RESET_ALL;
        end

        if (i_restart) begin
            state_next = RESET_ALL;
            retry_next = '0;
        end

        // Timer restarts on every state entry; saturates while parked
        if (i_restart || (state_next != state_reg))
            timer_next = '0;
        else if (timer_reg == TIMER_TOP)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + 1'b1;
    end

    // Output decode from the next state so outputs move with o_state
    always_comb begin
        csr_rst_n_next = 1'b0;
        tx_rst_n_next  = 1'b0;
        rx_rst_n_next  = 1'b0;
        link_up_next   = 1'b0;
        fail_next      = 1'b0;
        case (state_next)
            WAIT_EHIP: csr_rst_n_next = 1'b1;
            WAIT_TX, RX_RETRY: begin
                csr_rst_n_next = 1'b1;
                tx_rst_n_next  = 1'b1;
            end
            WAIT_RX: begin
                csr_rst_n_next = 1'b1;
                tx_rst_n_next  = 1'b1;
                rx_rst_n_next  = 1'b1;
            end
            LINK_UP: begin
                csr_rst_n_next = 1'b1;
                tx_rst_n_next  = 1'b1;
                rx_rst_n_next  = 1'b1;
                link_up_next   = 1'b1;
            end
            FAIL:    fail_next = 1'b1;
            default: ;
        endcase
    end

    assign o_csr_rst_n = csr_rst_n_reg;
    assign o_tx_rst_n  = tx_rst_n_reg;
    assign o_rx_rst_n  = rx_rst_n_reg;
    assign o_link_up   = link_up_reg;
    assign o_fail      = fail_reg;
    assign o_state     = state_reg;
    assign o_retry_cnt = retry_reg;

endmodule

// File: tb/tb_eth_link_reset_seq.sv
// Testbench for eth_link_reset_seq: directed bring-up/fault steps plus a
// randomized stretch, all compared each cycle against a behavioural model.
module tb_eth_link_reset_seq;

    localparam int H = 4;
    localparam int T = 100;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    logic pll = 1'b1, cdr = 1'b1, ehip = 1'b1, lanes = 1'b1, pcs = 1'b1;

    logic       csr_n, tx_n, rx_n, link_up, fail;
    logic [2:0] state;
    logic [3:0] retry;

    int errors = 0;
    int checks = 0;

    // Behavioural model: state number, dwell time, retry count, 2-cycle status delay
    int         m_st = 0;
    int         m_tmr = 0;
    int         m_retry = 0;
    logic [4:0] p0 = '0;
    logic [4:0] p1 = '0;

    eth_link_reset_seq #(
        .HOLD_CYCLES(H),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES(M)
    ) dut (
        .i_reconfig_clk(clk),
        .i_reconfig_reset(rst),
        .i_restart(restart),
        .i_tx_pll_locked(pll),
        .i_cdr_lock(cdr),
        .i_ehip_ready(ehip),
        .i_tx_lanes_stable(lanes),
        .i_rx_pcs_ready(pcs),
        .o_csr_rst_n(csr_n),
        .o_tx_rst_n(tx_n),
        .o_rx_rst_n(rx_n),
        .o_link_up(link_up),
        .o_fail(fail),
        .o_state(state),
        .o_retry_cnt(retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {csr, tx, rx, link_up, fail} expected for a given state number
    function automatic logic [4:0] exp_flags(input int st);
        case (st)
            1:       return 5'b10000;
            2, 5:    return 5'b11000;
            3:       return 5'b11100;
            4:       return 5'b11110;
            6:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Advance the model by one clock edge using the pins as they were before it
    task automatic model_edge();
        logic [4:0] s;
        logic       ok;
        int         nst;
        if (rst) begin
            m_st = 0; m_tmr = 0; m_retry = 0; p0 = '0; p1 = '0;
            return;
        end
        s  = p1;
        p1 = p0;
        p0 = {pll, cdr, ehip, lanes, pcs};
        if (restart) begin
            m_st = 0; m_tmr = 0; m_retry = 0;
            return;
        end
        nst = m_st;
        case (m_st)
            0: if (m_tmr == H - 1) nst = 1;
            5: if (m_tmr == H - 1) nst = 2;
            1, 2, 3: begin
                if (m_st == 1)      ok = s[2] & s[4];
                else if (m_st == 2) ok = s[1] & s[3];
                else                ok = s[0];
                if (ok) nst = m_st + 1;
                else if (m_tmr == T - 1) begin
                    m_retry = (m_retry + 1 > M) ? M : m_retry + 1;
                    if (m_retry == M)  nst = 6;
                    else if (m_st == 3) nst = 5;
                    else               nst = 0;
                end
            end
            4: begin
                if (!s[4])      nst = 0;
                else if (!s[0]) nst = 5;
            end
            default: ;
        endcase
        m_tmr = (nst != m_st) ? 0 : m_tmr + 1;
        m_st  = nst;
    endtask

    // One clock: update model at the edge, compare all outputs 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle",
            32'({csr_n, tx_n, rx_n, link_up, fail, state, retry}),
            32'({exp_flags(m_st), 3'(m_st), 4'(m_retry)}));
    endtask

    int n;
    int csr_at, tx_at, rx_at, link_at;
    int hold, bad, dwell;

    initial begin
        // Reset with all status high
        repeat (3) tick();
        chk("reset_state", 32'({csr_n, tx_n, rx_n, link_up, fail, state, retry}), 32'd0);

        // Nominal bring-up
        rst = 1'b0;
        csr_at = -1; tx_at = -1; rx_at = -1; link_at = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (csr_n && csr_at < 0)   csr_at = c;
            if (tx_n && tx_at < 0)     tx_at = c;
            if (rx_n && rx_at < 0)     rx_at = c;
            if (link_up && link_at < 0) link_at = c;
        end
        chk("csr_rise", csr_at, 4);
        chk("tx_rise", tx_at, 5);
        chk("rx_rise", rx_at, 6);
        chk("link_rise", link_at, 7);
        chk("bringup_retry", 32'(retry), 32'd0);

        // Drop rx_pcs_ready in LINK_UP
        pcs = 1'b0;
        n = 0;
        while (link_up && n < 10) begin tick(); n++; end
        chk("pcs_drop_latency", n, 3);
        pcs = 1'b1;
        hold = (state == 3'd5 && !rx_n) ? 1 : 0;
        bad  = (!csr_n || !tx_n) ? 1 : 0;
        for (int c = 0; c < 40 && !link_up; c++) begin
            tick();
            if (state == 3'd5 && !rx_n) hold++;
            if (!csr_n || !tx_n) bad++;
        end
        chk("rx_retry_hold", hold, 4);
        chk("csr_tx_stay_high", bad, 0);
        chk("relink", 32'(link_up), 32'd1);
        chk("relink_retry", 32'(retry), 32'd0);

        // Drop tx_pll_locked in LINK_UP
        pll = 1'b0;
        n = 0;
        while (csr_n && n < 10) begin tick(); n++; end
        chk("pll_drop_latency", n, 3);
        chk("pll_drop_resets", 32'({tx_n, rx_n, state}), 32'd0);
        pll = 1'b1;
        for (int c = 0; c < 40 && !link_up; c++) tick();
        chk("replay_link", 32'(link_up), 32'd1);

        // Randomized stretch against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: pll   = ($urandom_range(0, 3) != 0);
                    1: cdr   = ($urandom_range(0, 3) != 0);
                    2: ehip  = ($urandom_range(0, 3) != 0);
                    3: lanes = ($urandom_range(0, 3) != 0);
                    default: pcs = ($urandom_range(0, 3) != 0);
                endcase
            end
            restart = ($urandom_range(0, 199) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        restart = 1'b0;

        // ehip_ready stuck low: two timeouts lead to FAIL
        pll = 1'b1; cdr = 1'b1; lanes = 1'b1; pcs = 1'b1; ehip = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_clear", 32'({state, retry, fail}), 32'd0);
        dwell = 0;
        for (int c = 0; c < 200 && retry == 4'd0; c++) begin
            tick();
            if (state == 3'd1) dwell++;
        end
        chk("ehip_dwell", dwell, 100);
        chk("timeout1_state", 32'(state), 32'd0);
        chk("timeout1_retry", 32'(retry), 32'd1);
        for (int c = 0; c < 300 && !fail; c++) tick();
        chk("fail_outputs", 32'({fail, state, csr_n, tx_n, rx_n}), 32'({1'b1, 3'd6, 3'b000}));
        repeat (50) tick();
        chk("fail_hold", 32'({fail, state}), 32'({1'b1, 3'd6}));

        // Restart from FAIL
        ehip = 1'b1; pcs = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_in_fail", 32'({state, fail, retry}), 32'd0);

        // Restart coincident with a WAIT_RX timeout
        for (int c = 0; c < 20 && state != 3'd3; c++) tick();
        chk("reach_wait_rx", 32'(state), 32'd3);
        repeat (99) tick();
        chk("pre_timeout", 32'({state, retry}), 32'({3'd3, 4'd0}));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_at_timeout", 32'({state, fail, retry}), 32'd0);

        // Reset and restart together in WAIT_RX
        for (int c = 0; c < 20 && state != 3'd3; c++) tick();
        repeat (5) tick();
        chk("wait_rx_again", 32'(state), 32'd3);
        rst = 1'b1;
        restart = 1'b1;
        tick();
        chk("reset_over_restart", 32'({csr_n, tx_n, rx_n, link_up, fail, state, retry}), 32'd0);
        rst = 1'b0;
        restart = 1'b0;
        pcs = 1'b1;
        for (int c = 0; c < 40 && !link_up; c++) tick();
        chk("final_link", 32'(link_up), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
